cic_decim_sched: RTL and testbench

Sequencer for the CIC decimation datapath in the CLOCK_50 domain. It synchronises the codec LRCK and captures one AUD_IN sample per LRCK rising edge. It strobes the filter datapath with that sample and counts decimation phase. Every R-th filter result goes into a one-deep output buffer with a valid/ready handshake toward the I2S serializer or any other consumer.

---
 rtl/cic_decim_sched.sv | 163 ++++++++++++++++
 tb/tb_cic_decim_sched.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cic_decim_sched.sv
// CIC decimation sequencer: synchronises LRCK, strobes the filter once per sample,
// keeps every R-th result in a one-deep valid/ready buffer. Define CIC_DECIM_SCHED_DBG_EN for DROP_CNT.
module cic_decim_sched #(
  parameter int W       = 16,
  parameter int FLT_LAT = 1
) (
  input  logic         CLOCK_50,
  input  logic         RESET,
  input  logic         LRCK,
  input  logic [W-1:0] AUD_IN,
  input  logic         CFG_WE,
  input  logic [3:0]   CFG_R,
  output logic         FLT_EN,
  output logic [W-1:0] FLT_DIN,
  input  logic [W-1:0] FLT_DOUT,
  output logic [W-1:0] OUT_DATA,
  output logic         OUT_VALID,
  input  logic         OUT_READY,
  output logic [3:0]   PHASE,
  output logic         OVERRUN
`ifdef CIC_DECIM_SCHED_DBG_EN
  ,
  output logic [7:0]   DROP_CNT
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_FEED, S_WAIT, S_DONE} state_t;

  localparam logic [3:0] LAT = 4'(FLT_LAT);

  state_t       r_state;
  state_t       w_state_nxt;
  logic         w_flt_en;
  logic         r_lrck_s1;
  logic         r_lrck_s2;
  logic         r_lrck_d;
  logic [3:0]   r_cnt;
  logic [3:0]   r_rm1;
  logic [3:0]   r_pend_r;
  logic         r_pend_v;
  logic [3:0]   r_phase;
  logic [W-1:0] r_flt_din;
  logic [W-1:0] r_out_data;
  logic         r_out_valid;
  logic         r_overrun;

  logic         w_edge;
  logic         w_idle;
  logic         w_cfg_apply;
  logic [3:0]   w_cfg_val;
  logic         w_offer;
  logic         w_load;
  logic         w_drop;
  logic         w_ignore;

  assign w_edge      = r_lrck_s2 & ~r_lrck_d;
  assign w_idle      = (r_state == S_IDLE);
  // A write landing in an IDLE cycle takes effect at once, ahead of any edge in that cycle.
  assign w_cfg_apply = w_idle & (CFG_WE | r_pend_v);
  assign w_cfg_val   = CFG_WE ? CFG_R : r_pend_r;
  assign w_offer     = (r_state == S_DONE) && (r_phase == r_rm1);
  assign w_load      = w_offer && (!r_out_valid || OUT_READY);
  assign w_drop      = w_offer && r_out_valid && !OUT_READY;
  assign w_ignore    = w_edge && !w_idle;

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      r_lrck_s1 <= 1'b0;
      r_lrck_s2 <= 1'b0;
      r_lrck_d  <= 1'b0;
      r_state   <= S_IDLE;
    end else begin
      r_lrck_s1 <= LRCK;
      r_lrck_s2 <= r_lrck_s1;
      r_lrck_d  <= r_lrck_s2;
      r_state   <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_flt_en    = 1'b0;
    case (r_state)
      S_IDLE: if (w_edge) w_state_nxt = S_FEED;
      S_FEED: begin
        w_flt_en    = 1'b1;
        w_state_nxt = S_WAIT;
      end
      // WAIT lasts FLT_LAT cycles so DONE samples the result just as it becomes valid.
      S_WAIT: if (r_cnt <= 4'd1) w_state_nxt = S_DONE;
      S_DONE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      r_cnt       <= 4'd0;
      r_rm1       <= 4'd0;
      r_pend_r    <= 4'd0;
      r_pend_v    <= 1'b0;
      r_phase     <= 4'd0;
      r_flt_din   <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      if (w_idle && w_edge) r_flt_din <= AUD_IN;

      if (r_state == S_FEED) r_cnt <= LAT;
      else if (r_state == S_WAIT) r_cnt <= r_cnt - 4'd1;

      if (w_cfg_apply) begin
        r_rm1   <= w_cfg_val;
        r_phase <= 4'd0;
      end else if (r_state == S_DONE) begin
        r_phase <= w_offer ? 4'd0 : r_phase + 4'd1;
      end

      if (w_cfg_apply) begin
        r_pend_v <= 1'b0;
      end else if (CFG_WE) begin
        r_pend_v <= 1'b1;
        r_pend_r <= CFG_R;
      end

      if (w_load) begin
        r_out_data  <= FLT_DOUT;
        r_out_valid <= 1'b1;
      end else if (OUT_READY) begin
        r_out_valid <= 1'b0;
      end

      if (w_cfg_apply) r_overrun <= 1'b0;
      else if (w_drop || w_ignore) r_overrun <= 1'b1;
    end
  end

`ifdef CIC_DECIM_SCHED_DBG_EN
  logic [7:0] r_drop_cnt;
  logic [8:0] w_drop_sum;

  // A dropped result and an ignored edge can coincide in DONE; both are counted.
  assign w_drop_sum = {1'b0, r_drop_cnt} + {8'd0, w_drop} + {8'd0, w_ignore};

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) r_drop_cnt <= 8'd0;
    else if (w_cfg_apply) r_drop_cnt <= 8'd0;
    else if (w_drop_sum[8]) r_drop_cnt <= 8'hFF;
    else r_drop_cnt <= w_drop_sum[7:0];
  end

  assign DROP_CNT = r_drop_cnt;
`endif

  assign FLT_EN    = w_flt_en;
  assign FLT_DIN   = r_flt_din;
  assign OUT_DATA  = r_out_data;
  assign OUT_VALID = r_out_valid;
  assign PHASE     = r_phase;
  assign OVERRUN   = r_overrun;

endmodule

// File: tb/tb_cic_decim_sched.sv
// Bench for cic_decim_sched: behavioural filter, rise-level reference model and
// scoreboard of expected OUT_DATA transfers. DROP_CNT checked when CIC_DECIM_SCHED_DBG_EN is set.
module tb_cic_decim_sched;
  localparam int W = 16;
  localparam int FLT_LAT = 3;
  localparam logic [W-1:0] KEY = 16'h3C3C;

  logic         CLOCK_50;
  logic         RESET;
  logic         LRCK;
  logic [W-1:0] AUD_IN;
  logic         CFG_WE;
  logic [3:0]   CFG_R;
  logic         FLT_EN;
  logic [W-1:0] FLT_DIN;
  logic [W-1:0] FLT_DOUT = '0;
  logic [W-1:0] OUT_DATA;
  logic         OUT_VALID;
  logic         OUT_READY;
  logic [3:0]   PHASE;
  logic         OVERRUN;
`ifdef CIC_DECIM_SCHED_DBG_EN
  logic [7:0]   DROP_CNT;
`endif

  int n_total = 0;
  int n_bad   = 0;
  int n_en    = 0;
  int n_xfer  = 0;

  logic [W-1:0] exp_q[$];
  int   m_r     = 1;
  int   m_phase = 0;
  logic m_ovr   = 1'b0;
  int   m_drop  = 0;

  cic_decim_sched #(.W(W), .FLT_LAT(FLT_LAT)) dut (
    .CLOCK_50 (CLOCK_50),
    .RESET    (RESET),
    .LRCK     (LRCK),
    .AUD_IN   (AUD_IN),
    .CFG_WE   (CFG_WE),
    .CFG_R    (CFG_R),
    .FLT_EN   (FLT_EN),
    .FLT_DIN  (FLT_DIN),
    .FLT_DOUT (FLT_DOUT),
    .OUT_DATA (OUT_DATA),
    .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY),
    .PHASE    (PHASE),
    .OVERRUN  (OVERRUN)
`ifdef CIC_DECIM_SCHED_DBG_EN
    ,
    .DROP_CNT (DROP_CNT)
`endif
  );

  // clock / reset
  initial CLOCK_50 = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;

  // filter: result = FLT_DIN ^ KEY, valid FLT_LAT cycles after the strobe, junk before
  logic [W-1:0] f_pend = '0;
  int f_cnt = 0;
  always @(posedge CLOCK_50) begin
    if (FLT_EN) begin
      f_pend = FLT_DIN ^ KEY;
      f_cnt  = FLT_LAT;
      FLT_DOUT <= 16'hDEAD;
    end else if (f_cnt > 0) begin
      f_cnt = f_cnt - 1;
      if (f_cnt == 0) FLT_DOUT <= f_pend;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // scoreboard: every handshake must deliver the oldest expected word
  always @(negedge CLOCK_50) begin
    if (!RESET && FLT_EN) n_en++;
    if (!RESET && OUT_VALID && OUT_READY) begin
      n_xfer++;
      if (exp_q.size() == 0) chk("xfer_unexpected", exp_q.size(), 1);
      else chk("xfer_data", OUT_DATA, exp_q.pop_front());
    end
  end

  // reference model: one call per accepted LRCK rise; rdy is OUT_READY at decision time
  task automatic model_rise(input logic [W-1:0] s, input logic rdy);
    if (m_phase == m_r - 1) begin
      m_phase = 0;
      if (!rdy && exp_q.size() > 0) begin
        m_ovr = 1'b1;
        if (m_drop < 255) m_drop++;
      end else begin
        exp_q.push_back(s ^ KEY);
      end
    end else begin
      m_phase++;
    end
  endtask

  task automatic model_cfg(input int v);
    m_r = v + 1;
    m_phase = 0;
    m_ovr = 1'b0;
    m_drop = 0;
  endtask

  // driver tasks
  task automatic step();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic do_cfg(input logic [3:0] v);
    @(posedge CLOCK_50);
    #1;
    CFG_R = v;
    CFG_WE = 1'b1;
    step();
    CFG_WE = 1'b0;
    model_cfg(int'(v));
    chk("cfg_phase", PHASE, m_phase);
    chk("cfg_ovr", OVERRUN, m_ovr);
  endtask

  task automatic drive_rise(input logic [W-1:0] s, input logic rdy);
    OUT_READY = rdy;
    model_rise(s, rdy);
    AUD_IN = s;
    @(posedge CLOCK_50);
    #3 LRCK = 1'b1;
    repeat (3) @(posedge CLOCK_50);
    #3 LRCK = 1'b0;
    repeat (FLT_LAT + 6) @(posedge CLOCK_50);
    #1;
    chk("phase", PHASE, m_phase);
    chk("ovr", OVERRUN, m_ovr);
    if (rdy) chk("drain", exp_q.size(), 0);
  endtask

  // cycle-exact rise: E is the first edge to see LRCK high; expects R=1, empty buffer, OUT_READY=0
  task automatic lat_check(input logic [W-1:0] s);
    model_rise(s, 1'b0);
    AUD_IN = s;
    @(posedge CLOCK_50);
    #2 LRCK = 1'b1;
    step();
    for (int c = 0; c <= FLT_LAT + 5; c++) begin
      chk("en_timing", FLT_EN, 32'(c == 2));
      chk("valid_timing", OUT_VALID, 32'(c >= FLT_LAT + 4));
      step();
    end
    LRCK = 1'b0;
    chk("lat_data", OUT_DATA, s ^ KEY);
  endtask

  initial begin
    logic [W-1:0] s;
    int e0;
    int x0;
    RESET = 1'b1;
    LRCK = 1'b0;
    AUD_IN = '0;
    CFG_WE = 1'b0;
    CFG_R = 4'd0;
    OUT_READY = 1'b0;
    repeat (3) @(posedge CLOCK_50);
    #1;
    chk("rst_en", FLT_EN, 0);
    chk("rst_din", FLT_DIN, 0);
    chk("rst_data", OUT_DATA, 0);
    chk("rst_valid", OUT_VALID, 0);
    chk("rst_phase", PHASE, 0);
    chk("rst_ovr", OVERRUN, 0);
`ifdef CIC_DECIM_SCHED_DBG_EN
    chk("rst_drop", DROP_CNT, 0);
`endif
    RESET = 1'b0;
    repeat (2) step();

    // latency from the LRCK rise to FLT_EN and OUT_VALID
    lat_check(16'h1234);

    // consumer takes the old word in the very DONE cycle that loads the new one
    s = 16'h4321;
    model_rise(s, 1'b1);
    AUD_IN = s;
    @(posedge CLOCK_50);
    #2 LRCK = 1'b1;
    step();
    repeat (FLT_LAT + 3) step();
    OUT_READY = 1'b1;
    step();
    OUT_READY = 1'b0;
    LRCK = 1'b0;
    chk("swap_valid", OUT_VALID, 1);
    chk("swap_data", OUT_DATA, s ^ KEY);
    chk("swap_ovr", OVERRUN, 0);
    chk("swap_q", exp_q.size(), 1);

    // R=1, sixteen ramp samples, consumer always ready
    e0 = n_en;
    for (int i = 1; i <= 16; i++) drive_rise(W'(i), 1'b1);
    chk("r1_strobes", n_en - e0, 16);
    chk("r1_ovr", OVERRUN, 0);

    // R=4 over twelve rises: three outputs
    do_cfg(4'd3);
    x0 = n_xfer;
    for (int i = 0; i < 12; i++) drive_rise(W'($urandom), 1'b1);
    chk("r4_xfers", n_xfer - x0, 3);

    // R=1 with a stalled consumer: second result dropped
    do_cfg(4'd0);
    drive_rise(16'hAAAA ^ KEY, 1'b0);
    drive_rise(16'h5555 ^ KEY, 1'b0);
    chk("stall_data", OUT_DATA, 16'hAAAA);
    chk("stall_ovr", OVERRUN, 1);
`ifdef CIC_DECIM_SCHED_DBG_EN
    chk("stall_drop", DROP_CNT, m_drop);
`endif

    // config written during WAIT takes effect only back in IDLE
    OUT_READY = 1'b1;
    step();
    s = W'($urandom);
    model_rise(s, 1'b1);
    AUD_IN = s;
    @(posedge CLOCK_50);
    #2 LRCK = 1'b1;
    step();
    repeat (3) step();
    CFG_R = 4'd7;
    CFG_WE = 1'b1;
    step();
    CFG_WE = 1'b0;
    LRCK = 1'b0;
    repeat (FLT_LAT - 1) step();
    chk("pend_ovr_held", OVERRUN, m_ovr);
    repeat (4) step();
    model_cfg(7);
    chk("pend_phase", PHASE, 0);
    chk("pend_ovr", OVERRUN, m_ovr);
    chk("pend_drain", exp_q.size(), 0);
    x0 = n_xfer;
    for (int i = 0; i < 8; i++) drive_rise(W'($urandom), 1'b1);
    chk("r8_xfers", n_xfer - x0, 1);

    // second rise arriving while busy is ignored
    do_cfg(4'd0);
    e0 = n_en;
    s = W'($urandom);
    model_rise(s, 1'b1);
    AUD_IN = s;
    @(posedge CLOCK_50);
    #2 LRCK = 1'b1;
    step();
    step();
    LRCK = 1'b0;
    step();
    @(posedge CLOCK_50);
    #2 LRCK = 1'b1;
    repeat (FLT_LAT + 8) step();
    LRCK = 1'b0;
    repeat (3) step();
    m_ovr = 1'b1;
    if (m_drop < 255) m_drop++;
    chk("ign_strobes", n_en - e0, 1);
    chk("ign_ovr", OVERRUN, m_ovr);
    chk("ign_drain", exp_q.size(), 0);
`ifdef CIC_DECIM_SCHED_DBG_EN
    chk("ign_drop", DROP_CNT, m_drop);
`endif

    // random factors, data and consumer stalls
    for (int round = 0; round < 4; round++) begin
      do_cfg(4'($urandom_range(0, 15)));
      for (int i = 0; i < int'($urandom_range(4, 20)); i++)
        drive_rise(W'($urandom), logic'($urandom_range(0, 3) != 0));
`ifdef CIC_DECIM_SCHED_DBG_EN
      chk("rnd_drop", DROP_CNT, m_drop);
`endif
    end
    OUT_READY = 1'b1;
    repeat (3) step();
    chk("rnd_drain", exp_q.size(), 0);

    // reset during FEED with a word buffered
    do_cfg(4'd1);
    drive_rise(W'($urandom), 1'b0);
    drive_rise(W'($urandom), 1'b0);
    chk("pre_rst_valid", OUT_VALID, 1);
    AUD_IN = 16'h7E57;
    @(posedge CLOCK_50);
    #2 LRCK = 1'b1;
    step();
    repeat (2) step();
    chk("pre_rst_en", FLT_EN, 1);
    RESET = 1'b1;
    LRCK = 1'b0;
    #1;
    chk("arst_en", FLT_EN, 0);
    chk("arst_din", FLT_DIN, 0);
    chk("arst_data", OUT_DATA, 0);
    chk("arst_valid", OUT_VALID, 0);
    chk("arst_phase", PHASE, 0);
    chk("arst_ovr", OVERRUN, 0);
    exp_q.delete();
    model_cfg(0);
    repeat (2) @(posedge CLOCK_50);
    #2 RESET = 1'b0;
    step();
    lat_check(16'hBEEF);
    OUT_READY = 1'b1;
    repeat (2) step();
    chk("end_drain", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
